// File: rtl/rggen_rtl_pkg.sv
// Shared definitions for the rggen bit-field library: FSM state encodings
// and small elaboration-time helpers.
package rggen_rtl_pkg;

    // Pulse generator burst state.
    typedef enum logic [1:0] {
        RGGEN_PULSE_GEN_IDLE,
        RGGEN_PULSE_GEN_ISSUE,
        RGGEN_PULSE_GEN_GAP
    } rggen_pulse_gen_state_e;

    // Keeps derived widths legal when a parameter collapses them to zero.
    function automatic int rggen_clip_width(int width);
        return (width > 0) ? width : 1;
    endfunction

endpackage

// File: rtl/rggen_bit_field_if.sv
// Software-side access bundle for a single register bit field.
interface rggen_bit_field_if #(
    parameter int WIDTH = 8
);
    logic             write_valid;
    logic [WIDTH-1:0] write_mask;
    logic [WIDTH-1:0] write_data;
    logic [WIDTH-1:0] read_data;
    logic [WIDTH-1:0] value;

    modport master (
        output write_valid, write_mask, write_data,
        input  read_data, value
    );

    modport bit_field (
        input  write_valid, write_mask, write_data,
        output read_data, value
    );
endinterface

// File: rtl/rggen_bit_field_pulse_generator.sv
// Register bit field that converts a software-written count into that many
// valid/ack pulses toward hardware, with an optional idle gap between them.
// Readback returns the number of pulses still outstanding.
//
// Optional feature: define RGGEN_BIT_FIELD_PULSE_GENERATOR_DONE_EN to add
// o_done, a one-cycle registered flag raised after the transfer that drains
// the count (never on an abort by clear or by a zero write).
module rggen_bit_field_pulse_generator
    import rggen_rtl_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 0,
    parameter bit USE_CLEAR  = 1'b1
)(
    input  logic                  i_clk,
    input  logic                  i_rst,
    rggen_bit_field_if.bit_field  bit_field_if,
    input  logic                  i_clear,
    output logic                  o_pulse,
    input  logic                  i_ack,
    output logic                  o_busy,
    output logic [WIDTH-1:0]      o_remaining
`ifdef RGGEN_BIT_FIELD_PULSE_GENERATOR_DONE_EN
    ,
    output logic                  o_done
`endif
);

    localparam int TIMER_W = rggen_clip_width($clog2(GAP_CYCLES + 1));

    rggen_pulse_gen_state_e state_q;
    rggen_pulse_gen_state_e state_d;
    logic [WIDTH-1:0]       count_q;
    logic [WIDTH-1:0]       count_d;
    logic [TIMER_W-1:0]     timer_q;
    logic [TIMER_W-1:0]     timer_d;

    logic                   clear_hit;
    logic                   transfer;
    logic [WIDTH-1:0]       merged;

    assign clear_hit = (USE_CLEAR != 1'b0) && i_clear;
    assign transfer  = (state_q == RGGEN_PULSE_GEN_ISSUE) && i_ack;
    assign merged    = (count_q & ~bit_field_if.write_mask)
                     | (bit_field_if.write_data & bit_field_if.write_mask);

    // State, count and gap timer registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= RGGEN_PULSE_GEN_IDLE;
            count_q <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            timer_q <= timer_d;
        end
    end

    // Next state: clear beats write beats transfer beats gap countdown.
    // A write or clear landing on a transfer edge discards the decrement so
    // the software value stands exactly as written.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        timer_d = timer_q;
        if (clear_hit) begin
            state_d = RGGEN_PULSE_GEN_IDLE;
            count_d = '0;
            timer_d = '0;
        end else if (bit_field_if.write_valid) begin
            count_d = merged;
            timer_d = '0;
            state_d = (merged != '0) ? RGGEN_PULSE_GEN_ISSUE
                                     : RGGEN_PULSE_GEN_IDLE;
        end else begin
            case (state_q)
                RGGEN_PULSE_GEN_ISSUE: begin
                    // count_q is nonzero in ISSUE; the guard keeps it from wrapping
                    if (i_ack && (count_q != '0)) begin
                        count_d = count_q - 1'b1;
                        if (count_q == WIDTH'(1)) begin
                            state_d = RGGEN_PULSE_GEN_IDLE;
                        end else if (GAP_CYCLES > 0) begin
                            state_d = RGGEN_PULSE_GEN_GAP;
                            timer_d = TIMER_W'(GAP_CYCLES);
                        end
                    end
                end
                RGGEN_PULSE_GEN_GAP: begin
                    if (timer_q <= TIMER_W'(1)) begin
                        state_d = RGGEN_PULSE_GEN_ISSUE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // o_pulse decodes the state register only, so i_ack never reaches it
    // combinationally.
    assign o_pulse               = (state_q == RGGEN_PULSE_GEN_ISSUE);
    assign o_busy                = (state_q != RGGEN_PULSE_GEN_IDLE);
    assign o_remaining           = count_q;
    assign bit_field_if.read_data = count_q;
    assign bit_field_if.value     = count_q;

`ifdef RGGEN_BIT_FIELD_PULSE_GENERATOR_DONE_EN
    logic last_transfer;

    assign last_transfer = transfer && !clear_hit && !bit_field_if.write_valid
                        && (count_q == WIDTH'(1));

    // Flag the edge on which the final pulse was consumed.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_done <= 1'b0;
        end else begin
            o_done <= last_transfer;
        end
    end
`else
    logic unused_transfer;
    assign unused_transfer = transfer;
`endif

endmodule

// File: tb/tb_rggen_bit_field_pulse_generator.sv
// Randomized + directed bench for rggen_bit_field_pulse_generator. Three
// instances share stimulus: (GAP 0, clear on), (GAP 2, clear on),
// (GAP 1, clear ignored). The reference model tracks only the outstanding
// count and the number of cycles before the next pulse may be offered.
module tb_rggen_bit_field_pulse_generator;

    localparam int NDUT = 3;
    localparam int GAPS [NDUT] = '{0, 2, 1};
    localparam bit UCS  [NDUT] = '{1'b1, 1'b1, 1'b0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wv = 1'b0;
    logic [7:0] wmask = 8'hFF;
    logic [7:0] wdata = 8'h00;
    logic       clr = 1'b0;
    logic       ack = 1'b0;

    logic       pulse_o [NDUT];
    logic       busy_o  [NDUT];
    logic [7:0] rem_o   [NDUT];
    logic [7:0] rd_o    [NDUT];
    logic [7:0] val_o   [NDUT];
`ifdef RGGEN_BIT_FIELD_PULSE_GENERATOR_DONE_EN
    logic       done_o  [NDUT];
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        rggen_bit_field_if #(.WIDTH(8)) bif ();
        assign bif.write_valid = wv;
        assign bif.write_mask  = wmask;
        assign bif.write_data  = wdata;
        assign rd_o[g]         = bif.read_data;
        assign val_o[g]        = bif.value;
        rggen_bit_field_pulse_generator #(
            .WIDTH(8), .GAP_CYCLES(GAPS[g]), .USE_CLEAR(UCS[g])
        ) u_dut (
            .i_clk(clk), .i_rst(rst), .bit_field_if(bif), .i_clear(clr),
            .o_pulse(pulse_o[g]), .i_ack(ack), .o_busy(busy_o[g]),
            .o_remaining(rem_o[g])
`ifdef RGGEN_BIT_FIELD_PULSE_GENERATOR_DONE_EN
            , .o_done(done_o[g])
`endif
        );
    end

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // reference: outstanding count, cycles left before a pulse may show
    int m_cnt  [NDUT];
    int m_wait [NDUT];
    bit m_done [NDUT];
    int xfers  [NDUT];
    int hi_cyc [NDUT];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic model_clear();
        for (int g = 0; g < NDUT; g++) begin
            m_cnt[g] = 0; m_wait[g] = 0; m_done[g] = 1'b0;
        end
    endtask

    task automatic compare_all();
        for (int g = 0; g < NDUT; g++) begin
            chk($sformatf("pulse%0d", g), int'(pulse_o[g]),
                int'(m_cnt[g] != 0 && m_wait[g] == 0));
            chk($sformatf("busy%0d", g), int'(busy_o[g]), int'(m_cnt[g] != 0));
            chk($sformatf("rem%0d", g), int'(rem_o[g]), m_cnt[g]);
            chk($sformatf("rdata%0d", g), int'(rd_o[g]), m_cnt[g]);
            chk($sformatf("value%0d", g), int'(val_o[g]), m_cnt[g]);
`ifdef RGGEN_BIT_FIELD_PULSE_GENERATOR_DONE_EN
            chk($sformatf("done%0d", g), int'(done_o[g]), int'(m_done[g]));
`endif
        end
    endtask

    // One clock: advance the model on the current inputs, then sample.
    task automatic step();
        int  ncnt  [NDUT];
        int  nwait [NDUT];
        bit  ndone [NDUT];
        bit  pv;
        for (int g = 0; g < NDUT; g++) begin
            if (pulse_o[g]) hi_cyc[g]++;
            if (pulse_o[g] && ack) xfers[g]++;
            pv       = (m_cnt[g] != 0) && (m_wait[g] == 0);
            ncnt[g]  = m_cnt[g];
            nwait[g] = (m_wait[g] > 0) ? m_wait[g] - 1 : 0;
            ndone[g] = 1'b0;
            if (UCS[g] && clr) begin
                ncnt[g] = 0; nwait[g] = 0;
            end else if (wv) begin
                ncnt[g]  = ((m_cnt[g] & ~int'(wmask)) | (int'(wdata) & int'(wmask))) & 255;
                nwait[g] = 0;
            end else if (pv && ack) begin
                ncnt[g]  = m_cnt[g] - 1;
                nwait[g] = (ncnt[g] != 0) ? GAPS[g] : 0;
                ndone[g] = (ncnt[g] == 0);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int g = 0; g < NDUT; g++) begin
            m_cnt[g] = ncnt[g]; m_wait[g] = nwait[g]; m_done[g] = ndone[g];
        end
        compare_all();
    endtask

    task automatic idle_inputs();
        wv = 1'b0; clr = 1'b0; wmask = 8'hFF; wdata = 8'h00;
    endtask

    task automatic write(input logic [7:0] d, input logic [7:0] m);
        wv = 1'b1; wdata = d; wmask = m;
        step();
        wv = 1'b0;
    endtask

    // Reset asserted between edges must clear outputs without a clock.
    task automatic async_reset();
        #3 rst = 1'b1;
        #1;
        for (int g = 0; g < NDUT; g++) begin
            chk($sformatf("arst_pulse%0d", g), int'(pulse_o[g]), 0);
            chk($sformatf("arst_busy%0d", g), int'(busy_o[g]), 0);
            chk($sformatf("arst_rem%0d", g), int'(rem_o[g]), 0);
        end
        model_clear();
        #1 rst = 1'b0;
    endtask

    initial begin
        int rises [$];
        bit prev;
        model_clear();
        for (int g = 0; g < NDUT; g++) begin xfers[g] = 0; hi_cyc[g] = 0; end

        #2;
        for (int g = 0; g < NDUT; g++) begin
            chk($sformatf("rst_pulse%0d", g), int'(pulse_o[g]), 0);
            chk($sformatf("rst_busy%0d", g), int'(busy_o[g]), 0);
            chk($sformatf("rst_rem%0d", g), int'(rem_o[g]), 0);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // back-to-back: 3 pulses in exactly 3 cycles on the GAP=0 instance
        ack = 1'b1;
        write(8'h03, 8'hFF);
        hi_cyc[0] = 0;
        chk("b2b_first_pulse", int'(pulse_o[0]), 1);
        chk("b2b_rem_start", int'(rem_o[0]), 3);
        for (int i = 0; i < 6; i++) step();
        chk("b2b_pulse_cycles", hi_cyc[0], 3);

        // gap + backpressure on the GAP=2 instance
        ack = 1'b0;
        write(8'h04, 8'hFF);
        for (int i = 0; i < 5; i++) step();
        chk("stall_hold", int'(pulse_o[1]), 1);
        chk("stall_rem", int'(rem_o[1]), 4);
        xfers[1] = 0;
        ack = 1'b1;
        prev = 1'b1;
        rises.push_back(cyc);
        for (int i = 0; i < 15; i++) begin
            step();
            if (pulse_o[1] && !prev) rises.push_back(cyc);
            prev = pulse_o[1];
        end
        chk("gap_xfers", xfers[1], 4);
        chk("gap_rises", rises.size(), 4);
        for (int i = 1; i < rises.size(); i++)
            chk("gap_spacing", rises[i] - rises[i-1], 3);

        // partial mask merge mid-burst
        ack = 1'b0;
        write(8'h05, 8'hFF);
        write(8'hF0, 8'hF0);
        chk("pmask_rem", int'(rem_o[0]), 8'hF5);
        chk("pmask_pulse", int'(pulse_o[0]), 1);

        // clear + write + ack together
        write(8'h05, 8'hFF);
        ack = 1'b1; clr = 1'b1; wv = 1'b1; wdata = 8'h07; wmask = 8'hFF;
        step();
        idle_inputs();
        chk("clr_rem0", int'(rem_o[0]), 0);
        chk("clr_pulse0", int'(pulse_o[0]), 0);
        chk("clr_rem1", int'(rem_o[1]), 0);
        chk("noclr_rem2", int'(rem_o[2]), 7);
        write(8'h00, 8'hFF);

        // zero write aborts after 4 transfers
        ack = 1'b1;
        write(8'd10, 8'hFF);
        for (int i = 0; i < 4; i++) step();
        chk("pre_abort_rem", int'(rem_o[0]), 6);
        write(8'h00, 8'hFF);
        chk("abort_rem", int'(rem_o[0]), 0);
        chk("abort_pulse", int'(pulse_o[0]), 0);
        step();

        // single-pulse burst, then async reset mid-burst
        write(8'h01, 8'hFF);
        step();
        step();
        write(8'd20, 8'hFF);
        step(); step();
        async_reset();
        step();

        // randomized traffic
        for (int i = 0; i < 700; i++) begin
            wv    = ($urandom_range(0, 11) == 0);
            wdata = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            wmask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            clr   = ($urandom_range(0, 24) == 0);
            ack   = ($urandom_range(0, 9) < 7);
            step();
            if ($urandom_range(0, 199) == 0) async_reset();
        end
        idle_inputs();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rggen_bit_field_pulse_generator.md
Name: rggen_bit_field_pulse_generator

Overview:
Register bit field that turns a software-written count into that many handshaked event pulses toward hardware.
- It is the transmit-side counterpart of the up/down event counter field.
- Software writes N through the bit-field interface. The block issues N valid/ack transfers on o_pulse/i_ack, with an optional idle gap between transfers.
- Readback shows the number of pulses still outstanding.

Parameters:
- WIDTH, 8: count register width; maximum burst is 2^WIDTH-1 pulses.
- GAP_CYCLES, 0: idle cycles inserted after each accepted pulse; 0 means back-to-back transfers.
- USE_CLEAR, 1: when 1, i_clear aborts the burst; when 0, i_clear is ignored.

Ports:
- i_clk, input, 1: clock.
- i_rst, input, 1: reset. One clock; reset is asynchronous and active-high.
- bit_field_if, modport rggen_bit_field_if.bit_field, WIDTH: software write/read access. Drives value and read_data = remaining count.
- i_clear, input, 1: synchronous abort of the burst.
- o_pulse, output, 1: pulse valid toward hardware.
- i_ack, input, 1: hardware accept. A transfer occurs when o_pulse && i_ack.
- o_busy, output, 1: burst in progress (state != IDLE).
- o_remaining, output, WIDTH: outstanding pulse count.

Behaviour:
Reset values (i_rst high, asynchronous): state IDLE, count 0, gap timer 0, o_pulse 0, o_busy 0, o_remaining 0.

States:
- IDLE: o_pulse=0.
- ISSUE: o_pulse=1, held until i_ack.
- GAP: o_pulse=0; gap timer counts down.

Per-edge priority, highest first:
1. Clear: if USE_CLEAR && i_clear, then count=0 and state=IDLE.
2. Write: if write_valid, merge count[i]=write_data[i] where mask[i]. If the merged value is nonzero, state=ISSUE; otherwise state=IDLE. Write takes effect in any state.
3. Transfer: in ISSUE with i_ack, count=count-1.
   - If the new count is 0, state=IDLE.
   - Else if GAP_CYCLES>0, state=GAP with timer=GAP_CYCLES.
   - Else stay in ISSUE, so o_pulse stays high for the next transfer.
4. Gap: in GAP, timer decrements. On the cycle the timer reaches 1, the next state is ISSUE.

Timing and boundary rules:
- Latency: write accepted at edge t, o_pulse=1 from cycle t+1. With GAP_CYCLES=0 and i_ack held high, N pulses take exactly N cycles.
- Pulse spacing: with GAP_CYCLES=G and i_ack tied high, o_pulse rises every G+1 cycles.
- Write or clear coinciding with a transfer: the transfer is not subtracted. Hardware has consumed that pulse, but the new count stands as written.
- Writing 0 during a burst aborts it, same effect as clear.
- Count never wraps: decrement happens only from count>=1.
- No extra pulse is issued after count reaches 0.
- o_pulse is driven only by the state register; there is no combinational path from i_ack to o_pulse.
- Gap timer width = rggen_clip_width($clog2(GAP_CYCLES+1)).
- Reset mid-burst: immediate return to IDLE with o_pulse=0; pulses already transferred are not replayed.

Optional Feature:
Macro RGGEN_BIT_FIELD_PULSE_GENERATOR_DONE_EN.
- Defined: adds port o_done (output, 1). o_done is a single-cycle registered pulse on the cycle after the final transfer takes count to 0. It is not raised on abort by clear or by writing 0. It resets to 0.
- Undefined: no o_done port and no associated logic.

Decomposition:
- rggen_rtl_pkg gains typedef enum logic [1:0] rggen_pulse_gen_state_e {RGGEN_PULSE_GEN_IDLE, RGGEN_PULSE_GEN_ISSUE, RGGEN_PULSE_GEN_GAP}.
- The existing rggen_clip_width is reused for the timer width.
- No sub-module: count, gap timer and FSM are small and tightly coupled, so they stay in one module.

Test Plan:
- Back-to-back: WIDTH=8, GAP_CYCLES=0, i_ack=1, write 8'h03 with full mask -> o_pulse high for exactly 3 consecutive cycles starting the cycle after the write; o_remaining reads 3,2,1,0; o_busy falls with o_pulse.
- Gap and backpressure: GAP_CYCLES=2, write 4, i_ack low for 5 cycles then high -> o_pulse held through the stall; afterwards o_pulse rises every 3 cycles; 4 transfers total.
- Partial mask: count=8'h05 mid-burst, write data 8'hF0 with mask 8'hF0 -> count=8'hF5 and the burst continues without interruption.
- Clear vs transfer: i_clear, write_valid and i_ack all high on the same edge -> count=0, IDLE, o_pulse=0 next cycle; repeat with USE_CLEAR=0 -> the write value is loaded.
- Abort by zero write: burst of 10, write 0 after 4 transfers -> o_pulse=0 next cycle, o_remaining=0; o_done stays low when the macro is defined.
- Async reset: assert i_rst mid-burst between clock edges -> o_pulse, o_busy and o_remaining go to 0 immediately. With the macro defined, a completed burst of 1 gives exactly one o_done pulse one cycle after the ack.
